control_unit_pipe: RTL and testbench
====================================

// Module: control_unit_pipe
// PURPOSE
//  Parametrised ID-stage control generator: decodes the 32-bit ARM instruction, evaluates the
//  condition field against the current flags and drives control through a STAGES-deep register
//  pipe into EX. Adds stall hold, flush-to-bubble, condition cancel and undefined-class detection.
//  Sits between the IF/ID instruction register and the EX-stage control consumers.
// PARAMETERS
//  STAGES    1   control register depth, 1..3; output latency in cycles
//  COND_EN   1   1: evaluate I[31:28] vs flags; 0: every instruction treated as AL
//  CNT_W     16  width of saturating cancelled-instruction counter
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-high reset
//  instr        in   32  instruction from IF/ID
//  instr_valid  in   1   instr holds a real instruction
//  stall        in   1   hold all stages (hazard unit)
//  flush        in   1   clear all stages to bubble (branch taken)
//  flags        in   4   {N,Z,C,V} from status register
//  ctl_valid    out  1   output stage holds a live instruction
//  shift_imm    out  1   shifter-operand select
//  alu_op       out  4   ALU opcode
//  mem_size     out  2   2'b00 byte, 2'b10 word
//  mem_enable   out  1   data-memory access
//  mem_rw       out  1   1 write (store), 0 read
//  load_inst    out  1   load, writeback from memory
//  s_bit        out  1   update flags
//  rf_enable    out  1   register-file write
//  b_instr      out  1   branch
//  b_l          out  1   branch-with-link
//  rd           out  4   destination register I[15:12] (14 for B/L)
//  undef        out  1   live instruction had unsupported class
//  cancel_cnt   out  CNT_W  instructions cancelled by condition (saturating)
// BEHAVIOUR
//  Reset: every stage and every output 0; cancel_cnt 0. Reset beats flush and stall.
//  Decode (combinational, stage 0 input), by I[27:25]:
//   all-zero instr or !instr_valid -> bubble (all controls 0, ctl_valid 0).
//   000/001 data proc: alu_op=I[24:21], s_bit=I[20], shift_imm=1, rf_enable=1 except
//     opcodes 10xx (TST/TEQ/CMP/CMN): rf_enable 0, s_bit forced 1.
//   010/011 load/store: mem_enable 1, shift_imm 1, alu_op = I[23] ? 4'b0100 : 4'b0010,
//     mem_size = I[22] ? 2'b00 : 2'b10, load_inst=I[20], mem_rw=~I[20], rf_enable=I[20].
//   101 branch: b_instr 1, b_l=I[24], rf_enable=I[24], rd=4'd14, alu_op 0.
//   100/110/111: bubble controls, ctl_valid 1, undef 1.
//  Condition: COND_EN=1 and cond false -> entry becomes bubble, ctl_valid 0, cancel_cnt+1
//   (saturates at all-ones; increments only on cycles where stage 0 actually loads).
//   cond 1111 treated as NV (always false).
//  Pipe: on each clk, stall=0 -> stage[k] <= stage[k-1]; stall=1 -> all stages hold.
//   flush=1 -> all stages <= bubble; flush beats stall; flushed/stalled instr never counted.
//  Outputs are the last stage register, no combinational path from instr to outputs.
//  Latency: instr sampled at edge n appears at outputs after edge n+STAGES-1.
// STRUCTURE
//  Package ctl_pkg: ctl_t struct (all control fields + valid + undef), CTL_BUBBLE constant,
//   ALU_ADD=4'b0100, ALU_SUB=4'b0010, SIZE_BYTE, SIZE_WORD, class codes, cond codes.
//  Sub-module cond_eval (cond[3:0], flags[3:0] -> pass): pure combinational ARM truth table.
//  Stage array: generate loop over STAGES instances of ctl_t registers.
// TESTING
//  STAGES=1: ADD R1 (E0811002) -> next edge alu_op 0100, rf_enable 1, rd 1, s_bit 0.
//  CMP (E1510002) -> rf_enable 0, s_bit 1; LDRB (E5D12004) -> mem_size 00, load 1, mem_rw 0.
//  BL (EB000010) -> b_instr 1, b_l 1, rd 14, rf_enable 1; B (EA000010) -> b_l 0, rf_enable 0.
//  flags Z=0, ADDEQ (00811002) -> ctl_valid 0, cancel_cnt 1; COND_EN=0 -> executes.
//  STAGES=3 stream of 4 instrs, stall 2 cycles mid-stream then flush+stall together ->
//   outputs hold during stall, all bubbles next edge after flush, no counter change.
//  Reset asserted mid-stream -> all outputs 0 next edge; CNT_W=2, 5 cancels -> cnt stays 3.

Source files
------------

// File: rtl/ctl_pkg.sv
// Shared types and encodings for the ID-stage control pipe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctl_pkg;

  // One pipe entry: every EX-side control plus liveness and the undefined-class marker.
  typedef struct packed {
    logic       valid;
    logic       undef;
    logic       shift_imm;
    logic [3:0] alu_op;
    logic [1:0] mem_size;
    logic       mem_enable;
    logic       mem_rw;
    logic       load_inst;
    logic       s_bit;
    logic       rf_enable;
    logic       b_instr;
    logic       b_l;
    logic [3:0] rd;
  } ctl_t;

  localparam ctl_t CTL_BUBBLE = '0;

  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [3:0] RD_LINK   = 4'd14;

  // Instruction class, I[27:25].
  typedef enum logic [2:0] {
    CLS_DP_REG = 3'b000,
    CLS_DP_IMM = 3'b001,
    CLS_LS_IMM = 3'b010,
    CLS_LS_REG = 3'b011,
    CLS_UND_4  = 3'b100,
    CLS_BRANCH = 3'b101,
    CLS_UND_6  = 3'b110,
    CLS_UND_7  = 3'b111
  } class_e;

  // Condition field, I[31:28].
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // TST/TEQ/CMP/CMN (opcodes 10xx) only set flags and never write a register.
  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: cond field against {N,Z,C,V}.
// Latency: purely combinational.
// Backpressure: none.
module cond_eval
  import ctl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Truth table; NV lands in the default and never passes.
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit_pipe.sv
// ID-stage control decode with condition cancel, pushed through a STAGES-deep register pipe.
// Latency: instr sampled at edge n is visible on the outputs after edge n+STAGES-1.
// Backpressure: stall holds every stage; flush bubbles every stage and wins over stall.
module control_unit_pipe
  import ctl_pkg::*;
#(
  parameter int STAGES  = 1,
  parameter int COND_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       flags,
  output logic             ctl_valid,
  output logic             shift_imm,
  output logic [3:0]       alu_op,
  output logic [1:0]       mem_size,
  output logic             mem_enable,
  output logic             mem_rw,
  output logic             load_inst,
  output logic             s_bit,
  output logic             rf_enable,
  output logic             b_instr,
  output logic             b_l,
  output logic [3:0]       rd,
  output logic             undef,
  output logic [CNT_W-1:0] cancel_cnt
);

  ctl_t             dec;
  ctl_t             stage_in;
  ctl_t             stage_d [STAGES];
  ctl_t             stage_q [STAGES];
  logic             cond_pass;
  logic             cond_ok;
  logic             cancel_evt;
  logic             load_en;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  cond_eval u_cond (
    .cond  (instr[31:28]),
    .flags (flags),
    .pass  (cond_pass)
  );

  // Decode the raw instruction into a control entry (bubble when nothing real is present).
  always_comb begin
    dec = CTL_BUBBLE;
    if (instr_valid && (instr != 32'd0)) begin
      dec.valid = 1'b1;
      case (class_e'(instr[27:25]))
        CLS_DP_REG, CLS_DP_IMM: begin
          dec.alu_op    = instr[24:21];
          dec.shift_imm = 1'b1;
          dec.rd        = instr[15:12];
          dec.s_bit     = instr[20] | is_test_op(instr[24:21]);
          dec.rf_enable = ~is_test_op(instr[24:21]);
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          dec.mem_enable = 1'b1;
          dec.shift_imm  = 1'b1;
          dec.alu_op     = instr[23] ? ALU_ADD : ALU_SUB;
          dec.mem_size   = instr[22] ? SIZE_BYTE : SIZE_WORD;
          dec.load_inst  = instr[20];
          dec.mem_rw     = ~instr[20];
          dec.rf_enable  = instr[20];
          dec.rd         = instr[15:12];
        end
        CLS_BRANCH: begin
          dec.b_instr   = 1'b1;
          dec.b_l       = instr[24];
          dec.rf_enable = instr[24];
          dec.rd        = RD_LINK;
        end
        default: dec.undef = 1'b1;
      endcase
    end
  end

  assign cond_ok    = (COND_EN == 0) || cond_pass;
  assign cancel_evt = dec.valid && !cond_ok;
  assign stage_in   = cancel_evt ? CTL_BUBBLE : dec;
  assign load_en    = !stall && !flush;

  // Saturating count of condition-cancelled instructions that actually entered stage 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en && cancel_evt && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Cancel counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Each stage takes the decoded entry (head) or its upstream neighbour.
    if (k == 0) begin : g_head
      assign stage_d[k] = stage_in;
    end else begin : g_link
      assign stage_d[k] = stage_q[k-1];
    end

    // Stage register: reset, then flush, then stall-hold, else advance.
    always_ff @(posedge clk) begin
      if (reset) begin
        stage_q[k] <= CTL_BUBBLE;
      end else if (flush) begin
        stage_q[k] <= CTL_BUBBLE;
      end else if (!stall) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign ctl_valid  = stage_q[STAGES-1].valid;
  assign undef      = stage_q[STAGES-1].undef;
  assign shift_imm  = stage_q[STAGES-1].shift_imm;
  assign alu_op     = stage_q[STAGES-1].alu_op;
  assign mem_size   = stage_q[STAGES-1].mem_size;
  assign mem_enable = stage_q[STAGES-1].mem_enable;
  assign mem_rw     = stage_q[STAGES-1].mem_rw;
  assign load_inst  = stage_q[STAGES-1].load_inst;
  assign s_bit      = stage_q[STAGES-1].s_bit;
  assign rf_enable  = stage_q[STAGES-1].rf_enable;
  assign b_instr    = stage_q[STAGES-1].b_instr;
  assign b_l        = stage_q[STAGES-1].b_l;
  assign rd         = stage_q[STAGES-1].rd;
  assign cancel_cnt = cnt_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed bench for control_unit_pipe: four configurations share one stimulus stream.
// Latency: checks sample 1ns after each rising edge.
// Backpressure: stall/flush driven directly from the stimulus steps.
module tb_control_unit_pipe;

  localparam logic [31:0] I_ADD   = 32'hE0811002;
  localparam logic [31:0] I_CMP   = 32'hE1510002;
  localparam logic [31:0] I_LDRB  = 32'hE5D12004;
  localparam logic [31:0] I_STR   = 32'hE5812000;
  localparam logic [31:0] I_BL    = 32'hEB000010;
  localparam logic [31:0] I_B     = 32'hEA000010;
  localparam logic [31:0] I_UND   = 32'hE8000000;
  localparam logic [31:0] I_ADDEQ = 32'h00811002;
  localparam logic [31:0] I_ADDNV = 32'hF0811002;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid, stall, flush;
  logic [3:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Per-DUT outputs; packed as {valid,undef,shift_imm,alu_op,mem_size,mem_en,mem_rw,load,s,rf,b,bl,rd}.
  logic        v1, u1, sh1, me1, rw1, ld1, s1, rf1, b1, bl1;
  logic [3:0]  op1, rd1;
  logic [1:0]  sz1;
  logic [15:0] cnt1;
  logic        vn, un, shn, men, rwn, ldn, sn, rfn, bn, bln;
  logic [3:0]  opn, rdn;
  logic [1:0]  szn;
  logic [15:0] cntn;
  logic        v3, u3, sh3, me3, rw3, ld3, s3, rf3, b3, bl3;
  logic [3:0]  op3, rd3;
  logic [1:0]  sz3;
  logic [15:0] cnt3;
  logic        vs, us, shs, mes, rws, lds, ss, rfs, bs, bls;
  logic [3:0]  ops, rds;
  logic [1:0]  szs;
  logic [1:0]  cnts;

  logic [19:0] obs1, obsn, obs3, obss;
  assign obs1 = {v1, u1, sh1, op1, sz1, me1, rw1, ld1, s1, rf1, b1, bl1, rd1};
  assign obsn = {vn, un, shn, opn, szn, men, rwn, ldn, sn, rfn, bn, bln, rdn};
  assign obs3 = {v3, u3, sh3, op3, sz3, me3, rw3, ld3, s3, rf3, b3, bl3, rd3};
  assign obss = {vs, us, shs, ops, szs, mes, rws, lds, ss, rfs, bs, bls, rds};

  control_unit_pipe #(.STAGES(1), .COND_EN(1), .CNT_W(16)) u_s1 (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .flush(flush), .flags(flags), .ctl_valid(v1), .shift_imm(sh1), .alu_op(op1),
    .mem_size(sz1), .mem_enable(me1), .mem_rw(rw1), .load_inst(ld1), .s_bit(s1),
    .rf_enable(rf1), .b_instr(b1), .b_l(bl1), .rd(rd1), .undef(u1), .cancel_cnt(cnt1));

  control_unit_pipe #(.STAGES(1), .COND_EN(0), .CNT_W(16)) u_nc (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .flush(flush), .flags(flags), .ctl_valid(vn), .shift_imm(shn), .alu_op(opn),
    .mem_size(szn), .mem_enable(men), .mem_rw(rwn), .load_inst(ldn), .s_bit(sn),
    .rf_enable(rfn), .b_instr(bn), .b_l(bln), .rd(rdn), .undef(un), .cancel_cnt(cntn));

  control_unit_pipe #(.STAGES(3), .COND_EN(1), .CNT_W(16)) u_s3 (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .flush(flush), .flags(flags), .ctl_valid(v3), .shift_imm(sh3), .alu_op(op3),
    .mem_size(sz3), .mem_enable(me3), .mem_rw(rw3), .load_inst(ld3), .s_bit(s3),
    .rf_enable(rf3), .b_instr(b3), .b_l(bl3), .rd(rd3), .undef(u3), .cancel_cnt(cnt3));

  control_unit_pipe #(.STAGES(1), .COND_EN(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .flush(flush), .flags(flags), .ctl_valid(vs), .shift_imm(shs), .alu_op(ops),
    .mem_size(szs), .mem_enable(mes), .mem_rw(rws), .load_inst(lds), .s_bit(ss),
    .rf_enable(rfs), .b_instr(bs), .b_l(bls), .rd(rds), .undef(us), .cancel_cnt(cnts));

  function automatic logic [19:0] pk(input logic v, input logic u, input logic sh,
                                     input logic [3:0] op, input logic [1:0] sz,
                                     input logic me, input logic rw, input logic ld,
                                     input logic s, input logic rf, input logic b,
                                     input logic bl, input logic [3:0] r);
    return {v, u, sh, op, sz, me, rw, ld, s, rf, b, bl, r};
  endfunction

  // Hand-derived control words for the directed instructions.
  localparam logic [19:0] E_BUB = 20'd0;
  logic [19:0] e_add, e_cmp, e_ldrb, e_str, e_bl, e_b, e_und;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] i, input logic v, input logic st, input logic fl);
    instr       = i;
    instr_valid = v;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    e_add  = pk(1, 0, 1, 4'b0100, 2'b00, 0, 0, 0, 0, 1, 0, 0, 4'd1);
    e_cmp  = pk(1, 0, 1, 4'b1010, 2'b00, 0, 0, 0, 1, 0, 0, 0, 4'd0);
    e_ldrb = pk(1, 0, 1, 4'b0100, 2'b00, 1, 0, 1, 0, 1, 0, 0, 4'd2);
    e_str  = pk(1, 0, 1, 4'b0100, 2'b10, 1, 1, 0, 0, 0, 0, 0, 4'd2);
    e_bl   = pk(1, 0, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 1, 1, 4'd14);
    e_b    = pk(1, 0, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1, 0, 4'd14);
    e_und  = pk(1, 1, 0, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0);

    reset = 1'b1; flags = 4'b0000;
    instr = '0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;

    // Reset wins even with a live instruction and stall+flush asserted.
    step(I_ADD, 1, 1, 1);
    step(I_ADD, 1, 0, 0);
    chk("rst_s1", obs1, E_BUB);
    chk("rst_s3", obs3, E_BUB);
    chk("rst_cnt1", cnt1, 0);
    reset = 1'b0;

    // Single-stage decode, one instruction per edge.
    step(I_ADD, 1, 0, 0);   chk("add", obs1, e_add);
    chk("add_sat", obss, e_add);
    step(I_CMP, 1, 0, 0);   chk("cmp", obs1, e_cmp);
    step(I_LDRB, 1, 0, 0);  chk("ldrb", obs1, e_ldrb);
    step(I_STR, 1, 0, 0);   chk("str", obs1, e_str);
    step(I_BL, 1, 0, 0);    chk("bl", obs1, e_bl);
    step(I_B, 1, 0, 0);     chk("b", obs1, e_b);
    step(I_UND, 1, 0, 0);   chk("undef", obs1, e_und);

    // Condition cancel: Z=0 so EQ fails; COND_EN=0 instance executes it.
    step(I_ADDEQ, 1, 0, 0);
    chk("addeq_cancel", obs1, E_BUB);
    chk("addeq_cnt", cnt1, 1);
    chk("addeq_nocond", obsn, e_add);
    chk("nocond_cnt", cntn, 0);
    flags = 4'b1111;
    step(I_ADDNV, 1, 0, 0);
    chk("nv_cancel", obs1, E_BUB);
    chk("nv_cnt", cnt1, 2);
    flags = 4'b0100;
    step(I_ADDEQ, 1, 0, 0);
    chk("addeq_pass", obs1, e_add);
    chk("addeq_pass_cnt", cnt1, 2);
    flags = 4'b0000;

    // Bubbles: invalid qualifier and all-zero word.
    step(I_ADD, 0, 0, 0);   chk("invalid", obs1, E_BUB);
    step(32'd0, 1, 0, 0);   chk("zero_instr", obs1, E_BUB);

    // Stall holds and does not count; flush bubbles and does not count.
    step(I_ADD, 1, 0, 0);   chk("pre_stall", obs1, e_add);
    step(I_ADDEQ, 1, 1, 0);
    chk("stall_hold", obs1, e_add);
    chk("stall_cnt", cnt1, 2);
    step(I_ADDEQ, 1, 1, 1);
    chk("flush_bub", obs1, E_BUB);
    chk("flush_cnt", cnt1, 2);

    // Three-stage pipe: latency, stall hold, flush+stall.
    reset = 1'b1;
    step(32'd0, 0, 0, 0);
    reset = 1'b0;
    step(I_ADD, 1, 0, 0);   chk("s3_e1", obs3, E_BUB);
    step(I_CMP, 1, 0, 0);   chk("s3_e2", obs3, E_BUB);
    step(I_LDRB, 1, 0, 0);  chk("s3_e3", obs3, e_add);
    step(I_BL, 1, 1, 0);    chk("s3_stall1", obs3, e_add);
    step(I_BL, 1, 1, 0);    chk("s3_stall2", obs3, e_add);
    step(I_BL, 1, 0, 0);    chk("s3_resume", obs3, e_cmp);
    step(I_ADDEQ, 1, 1, 1);
    chk("s3_flush", obs3, E_BUB);
    chk("s3_flush_cnt", cnt3, 0);
    step(32'd0, 0, 0, 0);   chk("s3_after_flush", obs3, E_BUB);

    // Reset mid-stream clears everything on the next edge.
    step(I_ADD, 1, 0, 0);
    step(I_ADD, 1, 0, 0);
    step(I_ADD, 1, 0, 0);   chk("s3_prerst", obs3, e_add);
    reset = 1'b1;
    step(I_ADD, 1, 0, 0);
    chk("midrst_s3", obs3, E_BUB);
    chk("midrst_s1", obs1, E_BUB);
    reset = 1'b0;

    // Saturation: five cancels into a 2-bit counter.
    for (int k = 0; k < 5; k++) step(I_ADDEQ, 1, 0, 0);
    chk("sat_cnt", cnts, 3);
    chk("wide_cnt", cnt1, 5);
    chk("sat_out", obss, E_BUB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
